// File: rtl/edge_detect_pkg.sv
// edge_detect_pkg: shared types and helpers for the multi-channel edge detector.
// Debounce support is selected with EDGE_DEBOUNCE_EN.
package edge_detect_pkg;
  typedef enum logic [1:0] {EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH} edge_mode_t;
  localparam int MAX_CH = 32;
`ifdef EDGE_DEBOUNCE_EN
  localparam bit DEBOUNCE_EN = 1'b1;
`else
  localparam bit DEBOUNCE_EN = 1'b0;
`endif
  // Cycles after reset release before the delay reg matches the filtered level.
  function automatic int arm_cycles(int sync_stages, int db_cycles);
    return sync_stages + 1 + (DEBOUNCE_EN ? db_cycles : 0);
  endfunction
endpackage

// File: rtl/edge_detect_chan.sv
// edge_detect_chan: one channel of synchroniser, optional debounce (EDGE_DEBOUNCE_EN),
// delay register and mode-qualified edge decode.
module edge_detect_chan
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef EDGE_DEBOUNCE_EN
  , parameter int DB_CYCLES = 16
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       level,
  input  edge_mode_t mode,
  input  logic       armed,
  output logic       tick_next
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic dly_q, dly_d, synced, filt;
  assign synced = sync_q[SYNC_STAGES-1];
`ifdef EDGE_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic filt_q, filt_d, hit;
  // The filtered level moves on the cycle the mismatch count reaches DB_CYCLES.
  always_comb begin
    hit = cnt_q == CW'(DB_CYCLES - 1);
    cnt_d = (synced == filt_q || hit) ? '0 : cnt_q + 1'b1;
    filt_d = (synced != filt_q && hit) ? synced : filt_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt_q <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      filt_q <= filt_d;
    end
  assign filt = filt_q;
`else
  assign filt = synced;
`endif
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], level};
    dly_d = filt;
    tick_next = armed & (((mode == EDGE_RISE || mode == EDGE_BOTH) & filt & ~dly_q) |
                         ((mode == EDGE_FALL || mode == EDGE_BOTH) & ~filt & dly_q));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync_q <= '0;
      dly_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q <= dly_d;
    end
endmodule

// File: rtl/edge_detect_multi.sv
// edge_detect_multi: N_CH edge detectors with arming window, tick/pending registers and irq.
// Define EDGE_DEBOUNCE_EN to add a DB_CYCLES stability filter per channel.
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_CH-1:0]   level,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   clr,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   pending,
  output logic              irq
);
  localparam int ARM = arm_cycles(SYNC_STAGES, DB_CYCLES);
  localparam int AW = $clog2(ARM + 1);
  logic [AW-1:0] arm_q, arm_d;
  logic [N_CH-1:0] tick_q, tick_d, pending_q, pending_d;
  logic armed;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_detect_chan #(
      .SYNC_STAGES(SYNC_STAGES)
`ifdef EDGE_DEBOUNCE_EN
      , .DB_CYCLES(DB_CYCLES)
`endif
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .level    (level[i]),
      .mode     (edge_mode_t'(mode[2*i +: 2])),
      .armed    (armed),
      .tick_next(tick_d[i])
    );
  end
  // Set wins over a same-cycle clear so no edge is ever lost.
  always_comb begin
    armed = arm_q == AW'(ARM);
    arm_d = armed ? arm_q : arm_q + 1'b1;
    pending_d = (pending_q & ~clr) | tick_d;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      arm_q <= '0;
      tick_q <= '0;
      pending_q <= '0;
    end else begin
      arm_q <= arm_d;
      tick_q <= tick_d;
      pending_q <= pending_d;
    end
  assign tick = tick_q;
  assign pending = pending_q;
  assign irq = |pending_q;
endmodule

// File: tb/tb_edge_detect_multi.sv
// tb_edge_detect_multi: directed scoreboard bench for edge_detect_multi (N_CH=4, SYNC_STAGES=2, DB_CYCLES=4).
module tb_edge_detect_multi;
  import edge_detect_pkg::*;
`ifdef EDGE_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif
  typedef struct {int c; logic [3:0] m;} exp_t;
  exp_t q[$];
  logic clk = 1'b0, reset_n = 1'b0, irq;
  logic [3:0] level, clr, tick, pending;
  logic [7:0] mode;
  int checks = 0, failures = 0, cyc = 0;

  edge_detect_multi #(.N_CH(4), .SYNC_STAGES(2), .DB_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .level(level), .mode(mode), .clr(clr),
    .tick(tick), .pending(pending), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_tick(input logic [3:0] m);
    q.push_back(exp_t'{cyc + LAT, m});
  endtask

  // Every cycle out of reset, tick must equal the scheduled expectation or zero.
  always @(negedge clk) begin : mon
    logic [3:0] e;
    e = 4'b0;
    if (reset_n) begin
      if (q.size() > 0 && q[0].c == cyc) e = q.pop_front().m;
      check("tick", tick, e);
    end
  end

  initial begin
    level = 4'b0001;
    mode = 8'b0;
    mode[1:0] = EDGE_RISE;
    clr = 4'b0;
    step(3);
    check("reset_tick", tick, 4'b0);
    check("reset_pending", pending, 4'b0);
    check("reset_irq", {3'b0, irq}, 4'b0);
    reset_n = 1'b1;
    step(20);
    check("held_high_pending", pending, 4'b0);
    check("held_high_irq", {3'b0, irq}, 4'b0);
    level[0] = 1'b0;
    step(10);
    level[0] = 1'b1;
    expect_tick(4'b0001);
    step(12);
    check("rise_pending", pending, 4'b0001);
    check("rise_irq", {3'b0, irq}, 4'b0001);
    level[0] = 1'b0;
    step(12);
    check("fall_ignored_pending", pending, 4'b0001);
    clr = 4'b0001;
    step(1);
    clr = 4'b0;
    check("clr0_pending", pending, 4'b0);
    check("clr0_irq", {3'b0, irq}, 4'b0);
    mode[3:2] = EDGE_BOTH;
    level[1] = 1'b1;
    expect_tick(4'b0010);
    step(10);
    level[1] = 1'b0;
    expect_tick(4'b0010);
    step(12);
    check("both_pending", pending, 4'b0010);
    clr = 4'b0010;
    step(1);
    clr = 4'b0;
`ifndef EDGE_DEBOUNCE_EN
    for (int i = 0; i < 6; i++) begin
      level[1] = ~level[1];
      expect_tick(4'b0010);
      step(1);
    end
    step(10);
    check("b2b_pending", pending, 4'b0010);
    clr = 4'b0010;
    step(1);
    clr = 4'b0;
`endif
    mode[5:4] = EDGE_RISE;
    level[2] = 1'b1;
    expect_tick(4'b0100);
    step(LAT - 1);
    clr = 4'b0100;
    step(1);
    clr = 4'b0;
    check("set_wins_pending", pending, 4'b0100);
    check("set_wins_irq", {3'b0, irq}, 4'b0001);
    step(3);
    clr = 4'b0100;
    step(1);
    clr = 4'b0;
    check("clr2_pending", pending, 4'b0);
    check("clr2_irq", {3'b0, irq}, 4'b0);
    level[0] = 1'b1;
    expect_tick(4'b0001);
    step(12);
    mode[7:6] = EDGE_FALL;
    level[3] = 1'b1;
    step(12);
    check("fall_mode_rise_pending", pending, 4'b0001);
    mode[7:6] = EDGE_OFF;
    step(1);
    level[3] = 1'b0;
    step(12);
    check("off_retains_pending", pending, 4'b0001);
`ifdef EDGE_DEBOUNCE_EN
    clr = 4'b0001;
    level[0] = 1'b0;
    step(1);
    clr = 4'b0;
    step(15);
    level[0] = 1'b1;
    step(3);
    level[0] = 1'b0;
    step(15);
    check("glitch_pending", pending, 4'b0);
    level[0] = 1'b1;
    expect_tick(4'b0001);
    step(6);
    level[0] = 1'b0;
    step(15);
    check("debounced_pending", pending, 4'b0001);
`endif
    level[0] = 1'b0;
    step(12);
    checks++;
    assert (q.size() == 0) else begin
      failures++;
      $error("FAIL queue_drained observed=%0d expected=0", q.size());
    end
    level[0] = 1'b1;
    step(1);
    reset_n = 1'b0;
    step(2);
    check("midreset_tick", tick, 4'b0);
    check("midreset_pending", pending, 4'b0);
    check("midreset_irq", {3'b0, irq}, 4'b0);
    reset_n = 1'b1;
    step(20);
    check("rearm_pending", pending, 4'b0);
    check("rearm_irq", {3'b0, irq}, 4'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
